// File: rtl/alu_nibble_seq.sv
// Nibble-serial 8-bit Z80-style ALU: low nibble in LO, high nibble in HI, result/flags in DONE.
// Optional build macro ALU_NIBBLE_PARITY_EN makes P/V report even parity for AND/XOR/OR.
module alu_nibble_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] op1,
  input  logic [7:0] op2,
  input  logic       cy_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] flags
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR, OP_OR, OP_CP
  } op_e;

  state_e     state;
  op_e        op_q;
  logic [7:0] a_q, b_q;
  logic       cy_q;
  logic [3:0] lo_q;
  logic       h_q;

  logic       sub_op, logic_op, cin, parity;
  logic [4:0] lo_ext, hi_ext;
  logic [3:0] mid_ext;
  logic [3:0] lo_nib, hi_nib;
  logic [7:0] sum, yx_src, flags_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sub_op   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
    logic_op = (op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_OR);
    cin      = ((op_q == OP_ADC) || (op_q == OP_SBC)) && cy_q;

    if (sub_op) begin
      lo_ext  = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0, cin};
      hi_ext  = {1'b0, a_q[7:4]} - {1'b0, b_q[7:4]} - {4'b0, h_q};
      mid_ext = {1'b0, a_q[6:4]} - {1'b0, b_q[6:4]} - {3'b0, h_q};
    end else begin
      lo_ext  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, cin};
      hi_ext  = {1'b0, a_q[7:4]} + {1'b0, b_q[7:4]} + {4'b0, h_q};
      mid_ext = {1'b0, a_q[6:4]} + {1'b0, b_q[6:4]} + {3'b0, h_q};
    end

    lo_nib = lo_ext[3:0];
    hi_nib = hi_ext[3:0];
    case (op_q)
      OP_AND: begin lo_nib = a_q[3:0] & b_q[3:0]; hi_nib = a_q[7:4] & b_q[7:4]; end
      OP_XOR: begin lo_nib = a_q[3:0] ^ b_q[3:0]; hi_nib = a_q[7:4] ^ b_q[7:4]; end
      OP_OR:  begin lo_nib = a_q[3:0] | b_q[3:0]; hi_nib = a_q[7:4] | b_q[7:4]; end
      default: ;
    endcase

    sum    = {hi_nib, lo_q};
    yx_src = (op_q == OP_CP) ? b_q : sum;
`ifdef ALU_NIBBLE_PARITY_EN
    parity = ~^sum;
`else
    parity = 1'b0;
`endif

    // Overflow is the carry into bit 7 differing from the carry out of it.
    flags_next = {sum[7],
                  sum == 8'h00,
                  yx_src[5],
                  logic_op ? (op_q == OP_AND) : h_q,
                  yx_src[3],
                  logic_op ? parity : (hi_ext[4] ^ mid_ext[3]),
                  sub_op,
                  logic_op ? 1'b0 : hi_ext[4]};
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 8'h00;
      flags  <= 8'h00;
      h_q    <= 1'b0;
      lo_q   <= 4'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // NOTE: operand latches are deliberately not reset; they are always loaded before use.
            op_q  <= op_e'(op);
            a_q   <= op1;
            b_q   <= op2;
            cy_q  <= cy_in;
            state <= LO;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        LO: begin
          lo_q  <= lo_nib;
          h_q   <= lo_ext[4];
          state <= HI;
        end
        HI: begin
          result <= (op_q == OP_CP) ? a_q : sum;
          flags  <= flags_next;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: directed Z80 vectors, random ops vs an integer model,
// back-to-back issue, start-while-busy and mid-operation reset.
module tb_alu_nibble_seq;

  logic       clk = 1'b0;
  logic       reset, start, cy_in;
  logic [2:0] op;
  logic [7:0] op1, op2;
  logic       busy, done;
  logic [7:0] result, flags;

  int errors = 0;
  int checks = 0;

  alu_nibble_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op1(op1), .op2(op2),
    .cy_in(cy_in), .busy(busy), .done(done), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference model from the arithmetic rules: returns {result, flags}.
  function automatic logic [15:0] model(input int o, input int a, input int b, input int c);
    int full, lo, sres, sa, sb, cin;
    bit cf, hf, vf, nf;
    logic [7:0] res, yx;
    cin = (o == 1 || o == 3) ? c : 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    cf = 0; hf = 0; vf = 0; nf = 0; full = 0;
    case (o)
      0, 1: begin
        full = a + b + cin; lo = (a % 16) + (b % 16) + cin; sres = sa + sb + cin;
        cf = full > 255; hf = lo > 15; vf = (sres > 127) || (sres < -128);
      end
      2, 3, 7: begin
        full = a - b - cin; lo = (a % 16) - (b % 16) - cin; sres = sa - sb - cin;
        cf = full < 0; hf = lo < 0; vf = (sres > 127) || (sres < -128); nf = 1;
      end
      4: begin full = a & b; hf = 1; end
      5: full = a ^ b;
      default: full = a | b;
    endcase
    res = 8'(full);
    if (o >= 4 && o <= 6) begin
`ifdef ALU_NIBBLE_PARITY_EN
      vf = ($countones(res) % 2) == 0;
`else
      vf = 0;
`endif
    end
    yx = (o == 7) ? 8'(b) : res;
    return {(o == 7) ? 8'(a) : res,
            res[7], res == 8'h00, yx[5], hf, yx[3], vf, nf, cf};
  endfunction

  // One isolated operation; with noise set, start is re-pulsed with different operands while busy.
  task automatic run_op(input string tag, input int o, input int a, input int b, input int c,
                        input bit noise, input bit use_exp, input logic [15:0] exp_in);
    logic [15:0] exp;
    exp = use_exp ? exp_in : model(o, a, b, c);
    @(negedge clk);
    op = 3'(o); op1 = 8'(a); op2 = 8'(b); cy_in = c[0]; start = 1'b1;
    @(posedge clk); #1;
    check({tag, "/busy_lo"}, {7'b0, busy}, 8'h01);
    check({tag, "/done_lo"}, {7'b0, done}, 8'h00);
    if (noise) begin
      op = 3'($urandom_range(7)); op1 = ~op1; op2 = 8'($urandom); cy_in = ~cy_in;
    end else start = 1'b0;
    @(posedge clk); #1;
    check({tag, "/busy_hi"}, {7'b0, busy}, 8'h01);
    check({tag, "/done_hi"}, {7'b0, done}, 8'h00);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "/done"}, {7'b0, done}, 8'h01);
    check({tag, "/busy_done"}, {7'b0, busy}, 8'h00);
    check({tag, "/result"}, result, exp[15:8]);
    check({tag, "/flags"}, flags, exp[7:0]);
    @(posedge clk); #1;
    check({tag, "/done_pulse_end"}, {7'b0, done}, 8'h00);
    check({tag, "/result_hold"}, result, exp[15:8]);
  endtask

  initial begin
    logic [15:0] exp;
    int o, a, b, c;
    reset = 1'b1; start = 1'b0; op = 3'd0; op1 = 8'h00; op2 = 8'h00; cy_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/busy", {7'b0, busy}, 8'h00);
    check("reset/done", {7'b0, done}, 8'h00);
    check("reset/result", result, 8'h00);
    check("reset/flags", flags, 8'h00);
    @(negedge clk); reset = 1'b0;

    // Directed vectors with literal expected values.
    run_op("add_0f_01", 0, 8'h0F, 8'h01, 0, 0, 1, 16'h1010);
    run_op("add_7f_01", 0, 8'h7F, 8'h01, 0, 0, 1, 16'h8094);
    run_op("adc_ff_00", 1, 8'hFF, 8'h00, 1, 0, 1, 16'h0051);
    run_op("sub_00_01", 2, 8'h00, 8'h01, 0, 0, 1, 16'hFFBB);
    run_op("cp_05_05", 7, 8'h05, 8'h05, 0, 0, 1, 16'h0542);
`ifdef ALU_NIBBLE_PARITY_EN
    run_op("and_f0_0f", 4, 8'hF0, 8'h0F, 0, 0, 1, 16'h0054);
`else
    run_op("and_f0_0f", 4, 8'hF0, 8'h0F, 0, 0, 1, 16'h0050);
`endif
    run_op("sbc_10_0f", 3, 8'h10, 8'h0F, 1, 0, 0, 16'h0);
    run_op("add_busy_noise", 0, 8'h12, 8'h34, 0, 1, 1, 16'h4600);

    // Random operations, half of them with start toggled while busy.
    for (int i = 0; i < 40; i++) begin
      run_op("rand", int'($urandom_range(7)), int'($urandom_range(255)),
             int'($urandom_range(255)), int'($urandom_range(1)), bit'($urandom_range(1)), 0, 16'h0);
    end

    // Start held high: a new operation every 3 cycles.
    o = int'($urandom_range(7)); a = int'($urandom_range(255)); b = int'($urandom_range(255));
    c = int'($urandom_range(1));
    @(negedge clk);
    op = 3'(o); op1 = 8'(a); op2 = 8'(b); cy_in = c[0]; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = model(o, a, b, c);
      @(posedge clk); #1;
      check("b2b/done_lo", {7'b0, done}, 8'h00);
      @(posedge clk); #1;
      check("b2b/done_hi", {7'b0, done}, 8'h00);
      @(posedge clk); #1;
      check("b2b/done", {7'b0, done}, 8'h01);
      check("b2b/result", result, exp[15:8]);
      check("b2b/flags", flags, exp[7:0]);
      o = int'($urandom_range(7)); a = int'($urandom_range(255)); b = int'($urandom_range(255));
      c = int'($urandom_range(1));
      op = 3'(o); op1 = 8'(a); op2 = 8'(b); cy_in = c[0];
    end
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);

    // Reset while in HI aborts with no done pulse.
    @(negedge clk);
    op = 3'd0; op1 = 8'h55; op2 = 8'h66; cy_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort/busy_hi", {7'b0, busy}, 8'h01);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort/done", {7'b0, done}, 8'h00);
    check("abort/busy", {7'b0, busy}, 8'h00);
    check("abort/result", result, 8'h00);
    check("abort/flags", flags, 8'h00);
    @(posedge clk); #1;
    check("abort/no_late_done", {7'b0, done}, 8'h00);
    run_op("add_after_reset", 0, 8'h01, 8'h01, 0, 0, 1, 16'h0200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
